// File: rtl/mmio_gpio_if.sv
// mmio_gpio_if: single-beat MMIO bus between a bus master and the GPIO block.
//   cs_i     chip select for this block
//   addr_i   register index (0..7)
//   we_i     byte write enables, any bit set = write
//   re_i     byte read enables, any bit set = read
//   wdata_i  write data
//   rdata_o  combinational read data from the block
interface mmio_gpio_if;
  logic        cs_i;
  logic [2:0]  addr_i;
  logic [3:0]  we_i;
  logic [3:0]  re_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;

  modport master (
    output cs_i, addr_i, we_i, re_i, wdata_i,
    input  rdata_o
  );

  modport slave (
    input  cs_i, addr_i, we_i, re_i, wdata_i,
    output rdata_o
  );
endinterface

// File: rtl/mmio_gpio.sv
// mmio_gpio: memory-mapped GPIO block with debounced inputs and
// edge-triggered interrupt status.
//   clk     system clock, all state on rising edge
//   rst_n   asynchronous active-low reset
//   bus     MMIO slave port (cs/addr/we/re/wdata in, rdata out)
//   gpio_i  raw asynchronous input pins (switches)
//   gpio_o  registered output pins (LEDs)
//   irq_o   registered level interrupt, OR of pending STAT bits
// Registers: 0 OUT (RW), 1 IN (RO, debounced), 2 RISE_EN, 3 FALL_EN,
// 4 STAT (W1C), 5 OUT_SET (WO), 6 OUT_CLR (WO), 7 reserved.
module mmio_gpio #(
  parameter int unsigned IN_WIDTH  = 10,
  parameter int unsigned OUT_WIDTH = 10,
  parameter int unsigned DB_CYCLES = 50000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mmio_gpio_if.slave           bus,
  input  logic [IN_WIDTH-1:0]  gpio_i,
  output logic [OUT_WIDTH-1:0] gpio_o,
  output logic                 irq_o
);

  // Counter width keeps at least one bit so DB_CYCLES = 0 still elaborates.
  localparam int unsigned CW      = (DB_CYCLES == 0) ? 1 : $clog2(DB_CYCLES + 1);
  localparam int unsigned DB_LAST = (DB_CYCLES == 0) ? 0 : DB_CYCLES - 1;

  typedef enum logic [2:0] {
    REG_OUT     = 3'd0,
    REG_IN      = 3'd1,
    REG_RISE_EN = 3'd2,
    REG_FALL_EN = 3'd3,
    REG_STAT    = 3'd4,
    REG_OUT_SET = 3'd5,
    REG_OUT_CLR = 3'd6,
    REG_RSVD    = 3'd7
  } reg_e;

  logic [OUT_WIDTH-1:0] out_q, out_d;
  logic [IN_WIDTH-1:0]  rise_en_q, rise_en_d;
  logic [IN_WIDTH-1:0]  fall_en_q, fall_en_d;
  logic [IN_WIDTH-1:0]  stat_q, stat_d;
  logic [IN_WIDTH-1:0]  sync1_q, sync1_d;
  logic [IN_WIDTH-1:0]  sync2_q, sync2_d;
  logic [IN_WIDTH-1:0]  stable_q, stable_d;
  logic [CW-1:0]        cnt_q [IN_WIDTH];
  logic [CW-1:0]        cnt_d [IN_WIDTH];
  logic                 irq_q, irq_d;

  logic                 wr_en;
  logic                 rd_en;
  reg_e                 reg_sel;
  logic [IN_WIDTH-1:0]  rise;
  logic [IN_WIDTH-1:0]  fall;
  logic [IN_WIDTH-1:0]  w1c;
  logic                 unused_bus;

  // Upper write-data bits are unused when the pin counts are below 32.
  assign unused_bus = &{1'b0, bus.wdata_i};

  always_comb begin
    wr_en   = bus.cs_i & (|bus.we_i);
    rd_en   = bus.cs_i & (|bus.re_i);
    reg_sel = reg_e'(bus.addr_i);

    out_d     = out_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    sync1_d   = gpio_i;
    sync2_d   = sync1_q;
    stable_d  = stable_q;
    cnt_d     = cnt_q;
    w1c       = '0;

    // Debounce. The counter clears whenever the stable value flips, so it
    // never exceeds DB_CYCLES-1 and cannot wrap. With no debounce the
    // stable value tracks what sync2 is about to hold, giving the same
    // two-cycle pin latency as the synchronizer alone.
    for (int unsigned i = 0; i < IN_WIDTH; i++) begin
      if (DB_CYCLES == 0) begin
        stable_d[i] = sync1_q[i];
        cnt_d[i]    = '0;
      end else if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CW'(DB_LAST)) begin
          stable_d[i] = sync2_q[i];
          cnt_d[i]    = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end else begin
        cnt_d[i] = '0;
      end
    end

    rise = stable_d & ~stable_q;
    fall = ~stable_d & stable_q;

    if (wr_en) begin
      unique case (reg_sel)
        REG_OUT:     out_d     = bus.wdata_i[OUT_WIDTH-1:0];
        REG_RISE_EN: rise_en_d = bus.wdata_i[IN_WIDTH-1:0];
        REG_FALL_EN: fall_en_d = bus.wdata_i[IN_WIDTH-1:0];
        REG_STAT:    w1c       = bus.wdata_i[IN_WIDTH-1:0];
        REG_OUT_SET: out_d     = out_q | bus.wdata_i[OUT_WIDTH-1:0];
        REG_OUT_CLR: out_d     = out_q & ~bus.wdata_i[OUT_WIDTH-1:0];
        default:     ;
      endcase
    end

    // New events are ORed in after the clear so they win on a collision.
    stat_d = (stat_q & ~w1c) | (rise & rise_en_q) | (fall & fall_en_q);
    irq_d  = |stat_q;

    bus.rdata_o = '0;
    if (rd_en) begin
      unique case (reg_sel)
        REG_OUT:     bus.rdata_o = 32'(out_q);
        REG_IN:      bus.rdata_o = 32'(stable_q);
        REG_RISE_EN: bus.rdata_o = 32'(rise_en_q);
        REG_FALL_EN: bus.rdata_o = 32'(fall_en_q);
        REG_STAT:    bus.rdata_o = 32'(stat_q);
        default:     bus.rdata_o = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q     <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      stat_q    <= '0;
      sync1_q   <= '0;
      sync2_q   <= '0;
      stable_q  <= '0;
      irq_q     <= 1'b0;
      for (int unsigned i = 0; i < IN_WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      out_q     <= out_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      stat_q    <= stat_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      stable_q  <= stable_d;
      irq_q     <= irq_d;
      cnt_q     <= cnt_d;
    end
  end

  assign gpio_o = out_q;
  assign irq_o  = irq_q;

endmodule
